// File: rtl/botones_entrada.sv
// botones_entrada: syncs, debounces and edge-detects five push-buttons; test-entry FSM builds pulseTest.
// Define FEED_REPEAT_EN to auto-repeat botonFeed every REPEAT_PERIOD cycles while Feed is held.
module botones_entrada #(
   parameter int DEBOUNCE_MAX  = 50000,
   parameter int LONG_PRESS    = 2500000,
   parameter int TEST_WINDOW   = 50000000,
   parameter int REPEAT_PERIOD = 25000000,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_sleep,
   input  logic       btn_awake,
   input  logic       btn_feed,
   input  logic       btn_play,
   input  logic       btn_test,
   output logic       botonSleep,
   output logic       botonAwake,
   output logic       botonFeed,
   output logic       botonPlay,
   output logic       botonTest,
   output logic [3:0] pulseTest
);

   localparam int DW = (DEBOUNCE_MAX > 1) ? $clog2(DEBOUNCE_MAX) : 1;
   localparam int HW = (LONG_PRESS   > 1) ? $clog2(LONG_PRESS)   : 1;
   localparam int WW = (TEST_WINDOW  > 1) ? $clog2(TEST_WINDOW)  : 1;
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_MAX - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS - 1);
   localparam logic [WW-1:0] WIN_LAST  = WW'(TEST_WINDOW - 1);

   localparam int unsigned B_SLEEP = 0;
   localparam int unsigned B_AWAKE = 1;
   localparam int unsigned B_FEED  = 2;
   localparam int unsigned B_PLAY  = 3;
   localparam int unsigned B_TEST  = 4;

   if (DEBOUNCE_MAX < 1 || LONG_PRESS < 1 || TEST_WINDOW < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("botones_entrada: timing parameters must be >= 1");
   end

   typedef enum logic [2:0] {T_IDLE, T_HOLD, T_WAIT_REL, T_COUNT, T_COMMIT} test_state_e;

   logic [4:0]    btn_raw, btn_norm;
   logic [4:0]    sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d, rise;
   logic [DW-1:0] dcnt_q [5];
   logic [DW-1:0] dcnt_d [5];

   test_state_e   state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [WW-1:0] win_q, win_d;
   logic [3:0]    cnt_q, cnt_d;

   logic          sleep_q, sleep_d, awake_q, awake_d, feed_q, feed_d, play_q, play_d;
   logic          test_q, test_d;
   logic [3:0]    pulse_q, pulse_d;
   logic          idle, feed_rep;

   assign btn_raw  = {btn_test, btn_play, btn_feed, btn_awake, btn_sleep};
   assign btn_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

   // rise is combinational so the command flops and the FSM act on the same edge db changes
   always_comb begin
      sync1_d = btn_norm;
      sync2_d = sync1_q;
      db_d    = db_q;
      rise    = '0;
      for (int unsigned i = 0; i < 5; i++) begin
         dcnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (dcnt_q[i] == DB_LAST) begin
               db_d[i] = sync2_q[i];
               rise[i] = sync2_q[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      test_d  = 1'b0;
      pulse_d = '0;
      case (state_q)
         T_IDLE: begin
            if (rise[B_TEST]) begin
               state_d = T_HOLD;
               hold_d  = '0;
            end
         end
         T_HOLD: begin
            if (hold_q == HOLD_LAST) begin
               test_d  = 1'b1;
               state_d = T_WAIT_REL;
            end else if (!db_d[B_TEST]) begin
               state_d = T_IDLE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         T_WAIT_REL: begin
            if (!db_d[B_TEST]) begin
               state_d = T_COUNT;
               cnt_d   = '0;
               win_d   = '0;
            end
         end
         T_COUNT: begin
            if (rise[B_TEST]) begin
               if (cnt_q != 4'd9) cnt_d = cnt_q + 4'd1;
               win_d = '0;
            end else if (win_q == WIN_LAST) begin
               state_d = (cnt_q == 4'd0) ? T_IDLE : T_COMMIT;
            end else begin
               win_d = win_q + 1'b1;
            end
         end
         T_COMMIT: begin
            pulse_d = cnt_q;
            state_d = T_IDLE;
         end
         default: state_d = T_IDLE;
      endcase
   end

`ifdef FEED_REPEAT_EN
   localparam int RW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_PERIOD - 1);
   logic [RW-1:0] rep_q, rep_d;

   // counter restarts at the initial press because db_q is still low on that edge
   always_comb begin
      rep_d    = '0;
      feed_rep = 1'b0;
      if (db_q[B_FEED]) begin
         if (rep_q == REP_LAST) feed_rep = 1'b1;
         else                   rep_d    = rep_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rep_q <= '0;
      else     rep_q <= rep_d;
   end
`else
   assign feed_rep = 1'b0;
`endif

   assign idle = (state_q == T_IDLE);

   always_comb begin
      sleep_d = idle & rise[B_SLEEP] & ~rise[B_AWAKE];
      awake_d = idle & rise[B_AWAKE];
      feed_d  = idle & (rise[B_FEED] | feed_rep);
      play_d  = idle & rise[B_PLAY];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         dcnt_q  <= '{default: '0};
         state_q <= T_IDLE;
         hold_q  <= '0;
         win_q   <= '0;
         cnt_q   <= '0;
         sleep_q <= 1'b0;
         awake_q <= 1'b0;
         feed_q  <= 1'b0;
         play_q  <= 1'b0;
         test_q  <= 1'b0;
         pulse_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         db_q    <= db_d;
         dcnt_q  <= dcnt_d;
         state_q <= state_d;
         hold_q  <= hold_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         sleep_q <= sleep_d;
         awake_q <= awake_d;
         feed_q  <= feed_d;
         play_q  <= play_d;
         test_q  <= test_d;
         pulse_q <= pulse_d;
      end
   end

   assign botonSleep = sleep_q;
   assign botonAwake = awake_q;
   assign botonFeed  = feed_q;
   assign botonPlay  = play_q;
   assign botonTest  = test_q;
   assign pulseTest  = pulse_q;

endmodule
